// File: rtl/seg_pkg.sv
// Character codes and active-low glyphs shared by the seven-segment message scanner.
package seg_pkg;

    localparam int unsigned CODE_W = 5;

    localparam logic [CODE_W-1:0] CH_L     = 5'h10;
    localparam logic [CODE_W-1:0] CH_U     = 5'h11;
    localparam logic [CODE_W-1:0] CH_F     = 5'h12;
    localparam logic [CODE_W-1:0] CH_O     = 5'h13;
    localparam logic [CODE_W-1:0] CH_P     = 5'h14;
    localparam logic [CODE_W-1:0] CH_E     = 5'h15;
    localparam logic [CODE_W-1:0] CH_N     = 5'h16;
    localparam logic [CODE_W-1:0] CH_DASH  = 5'h17;
    localparam logic [CODE_W-1:0] CH_BLANK = 5'h1F;

    // Glyphs are {a,b,c,d,e,f,g}; a 0 bit lights the segment.
    localparam logic [6:0] GLYPH_L     = 7'b1110001;
    localparam logic [6:0] GLYPH_U     = 7'b1000001;
    localparam logic [6:0] GLYPH_F     = 7'b0111000;
    localparam logic [6:0] GLYPH_O     = 7'b0000001;
    localparam logic [6:0] GLYPH_P     = 7'b0011000;
    localparam logic [6:0] GLYPH_E     = 7'b0110000;
    localparam logic [6:0] GLYPH_N     = 7'b1101010;
    localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_glyph(input logic [3:0] val);
        logic [6:0] g;
        case (val)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            4'hF:    g = 7'b0111000;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational character-code to segment-pattern decoder with selectable output polarity.
module seg_glyph_rom
    import seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [6:0]        pattern_o
);

    logic [6:0] glyph_lo;

    always_comb begin
        glyph_lo = GLYPH_BLANK;
        if (!code_i[CODE_W-1]) begin
            glyph_lo = hex_glyph(code_i[3:0]);
        end else begin
            case (code_i)
                CH_L:    glyph_lo = GLYPH_L;
                CH_U:    glyph_lo = GLYPH_U;
                CH_F:    glyph_lo = GLYPH_F;
                CH_O:    glyph_lo = GLYPH_O;
                CH_P:    glyph_lo = GLYPH_P;
                CH_E:    glyph_lo = GLYPH_E;
                CH_N:    glyph_lo = GLYPH_N;
                CH_DASH: glyph_lo = GLYPH_DASH;
                default: glyph_lo = GLYPH_BLANK;
            endcase
        end
    end

    assign pattern_o = SEG_ACTIVE_LOW ? glyph_lo : ~glyph_lo;

endmodule

// File: rtl/seg_msg_scanner.sv
// Multiplexed N-digit seven-segment driver with frame-synchronous message commit.
// Optional digit blinking is built when SEG_BLINK_EN is defined.
module seg_msg_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned BLINK_FRAMES   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         msg_valid,
    output logic                         msg_ready,
    input  logic [NUM_DIGITS*CODE_W-1:0] msg_data,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]        blink_mask,
`endif
    output logic [6:0]                   seg,
    output logic [NUM_DIGITS-1:0]        an,
    output logic                         frame_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned BUF_W = NUM_DIGITS * CODE_W;

    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [BUF_W-1:0]      BUF_BLANK = {NUM_DIGITS{CH_BLANK}};

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seg_msg_scanner: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg_msg_scanner: SCAN_DIV must be >= 2");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
        $error("seg_msg_scanner: BLINK_FRAMES must be >= 1");
    end

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BUF_W-1:0]      shadow_q, shadow_d;
    logic [BUF_W-1:0]      active_q, active_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick, wrap, accept, commit, show;
    logic [CODE_W-1:0]     cur_code;
    logic [6:0]            cur_pattern;

    seg_glyph_rom #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_glyph_rom (
        .code_i   (cur_code),
        .pattern_o(cur_pattern)
    );

    always_comb begin
        tick   = (cnt_q == CNT_MAX);
        wrap   = tick && (idx_q == IDX_MAX);
        accept = msg_valid && !pending_q;
        // Commit uses the pending flag from before this edge, so a same-cycle accept waits a frame.
        commit = wrap && pending_q;

        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end

        shadow_d  = accept ? msg_data : shadow_q;
        active_d  = commit ? shadow_q : active_q;
        pending_d = pending_q;
        if (accept) begin
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
        end

        cur_code = CH_BLANK;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code = active_q[i*CODE_W +: CODE_W];
            end
        end

        // Each tick latches the digit the index points at, then the index moves on.
        seg_d = seg_q;
        an_d  = an_q;
        if (tick) begin
            seg_d = show ? cur_pattern : SEG_OFF;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_q == IDX_W'(i)) ^ AN_ACTIVE_LOW;
            end
        end

        frame_done_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= BUF_BLANK;
            active_q     <= BUF_BLANK;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned      FCNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] mask_shadow_q, mask_shadow_d;
    logic [NUM_DIGITS-1:0] mask_active_q, mask_active_d;
    logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
    logic                  phase_on_q, phase_on_d;
    logic                  cur_mask;

    always_comb begin
        mask_shadow_d = accept ? blink_mask : mask_shadow_q;
        mask_active_d = commit ? mask_shadow_q : mask_active_q;
        fcnt_d        = fcnt_q;
        phase_on_d    = phase_on_q;
        if (wrap) begin
            if (fcnt_q == FCNT_MAX) begin
                fcnt_d     = '0;
                phase_on_d = !phase_on_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end

        cur_mask = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_mask = mask_active_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_shadow_q <= '0;
            mask_active_q <= '0;
            fcnt_q        <= '0;
            phase_on_q    <= 1'b1;
        end else begin
            mask_shadow_q <= mask_shadow_d;
            mask_active_q <= mask_active_d;
            fcnt_q        <= fcnt_d;
            phase_on_q    <= phase_on_d;
        end
    end

    // Masked digits go dark in the off phase but keep their anode slot.
    assign show = phase_on_q || !cur_mask;
`else
    assign show = 1'b1;
`endif

    assign msg_ready  = !pending_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_msg_scanner.sv
// Directed self-checking bench for seg_msg_scanner (4 digits, 4-cycle slots, active-low).
module tb_seg_msg_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        msg_valid;
    logic        msg_ready;
    logic [19:0] msg_data;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
`ifdef SEG_BLINK_EN
    logic [3:0]  blink_mask;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    localparam logic [6:0] P_BLANK = 7'b1111111;
    localparam logic [6:0] P_F     = 7'b0111000;
    localparam logic [6:0] P_U     = 7'b1000001;
    localparam logic [6:0] P_L     = 7'b1110001;
    localparam logic [6:0] P_O     = 7'b0000001;
    localparam logic [6:0] P_P     = 7'b0011000;
    localparam logic [6:0] P_E     = 7'b0110000;
    localparam logic [6:0] P_N     = 7'b1101010;
    localparam logic [6:0] P_DASH  = 7'b1111110;
    localparam logic [6:0] P_1     = 7'b1001111;
    localparam logic [6:0] P_2     = 7'b0010010;
    localparam logic [6:0] P_A     = 7'b0001000;
    localparam logic [6:0] P_8     = 7'b0000000;

    localparam logic [3:0] AN_TAB   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [6:0] FULL_SEG [4] = '{P_F, P_U, P_L, P_L};
    localparam logic [6:0] A_SEG    [4] = '{P_O, P_P, P_E, P_N};
    localparam logic [6:0] B_SEG    [4] = '{P_1, P_2, P_A, P_DASH};
    localparam logic [6:0] C_SEG    [4] = '{P_F, P_8, P_BLANK, P_L};

    localparam logic [19:0] MSG_FULL = {5'h10, 5'h10, 5'h11, 5'h12};
    localparam logic [19:0] MSG_A    = {5'h16, 5'h15, 5'h14, 5'h13};
    localparam logic [19:0] MSG_B    = {5'h17, 5'h0A, 5'h02, 5'h01};
    localparam logic [19:0] MSG_C    = {5'h10, 5'h18, 5'h08, 5'h0F};
    localparam logic [19:0] MSG_D    = {5'h08, 5'h08, 5'h08, 5'h08};

    always #5 clk = ~clk;

    seg_msg_scanner #(
        .NUM_DIGITS    (4),
        .SCAN_DIV      (4),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1),
        .BLINK_FRAMES  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_data  (msg_data),
`ifdef SEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        msg_valid = 1'b0;
        msg_data  = '0;
`ifdef SEG_BLINK_EN
        blink_mask = '0;
`endif
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        compared++; if (an !== 4'b1111) begin mismatched++; $display("FAIL reset_an got %b want 1111", an); end
        compared++; if (seg !== P_BLANK) begin mismatched++; $display("FAIL reset_seg got %b want %b", seg, P_BLANK); end
        compared++; if (msg_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", msg_ready); end
        compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_fd got %b want 0", frame_done); end
        rst_n = 1'b1;
        cyc   = 0;
        run_to(3);
        compared++; if (an !== 4'b1111) begin mismatched++; $display("FAIL pre_tick_an got %b want 1111", an); end
        run_to(4);
        compared++; if (an !== 4'b1110) begin mismatched++; $display("FAIL first_tick_an got %b want 1110", an); end
        compared++; if (seg !== P_BLANK) begin mismatched++; $display("FAIL first_tick_seg got %b want %b", seg, P_BLANK); end
    endtask

    task automatic test_timing();
        logic [3:0] exp_an;
        while (cyc < 33) begin
            step();
            exp_an = AN_TAB[((cyc / 4) - 1) % 4];
            compared++;
            if (an !== exp_an) begin
                mismatched++; $display("FAIL timing_an cyc=%0d got %b want %b", cyc, an, exp_an);
            end
            compared++;
            if (frame_done !== (cyc % 16 == 0)) begin
                mismatched++;
                $display("FAIL timing_fd cyc=%0d got %b want %b", cyc, frame_done, (cyc % 16 == 0));
            end
        end
    endtask

    task automatic test_load_full();
        run_to(34);
        msg_valid = 1'b1;
        msg_data  = MSG_FULL;
        step();
        msg_valid = 1'b0;
        compared++; if (msg_ready !== 1'b0) begin mismatched++; $display("FAIL full_pending got %b want 0", msg_ready); end
        run_to(44);
        compared++; if (seg !== P_BLANK) begin mismatched++; $display("FAIL full_no_tear got %b want %b", seg, P_BLANK); end
        run_to(48);
        compared++; if (seg !== P_BLANK) begin mismatched++; $display("FAIL full_wrap_seg got %b want %b", seg, P_BLANK); end
        compared++; if (msg_ready !== 1'b1) begin mismatched++; $display("FAIL full_commit_ready got %b want 1", msg_ready); end
        while (cyc < 64) begin
            step();
            if (cyc % 4 == 0) begin
                compared++;
                if (seg !== FULL_SEG[((cyc / 4) - 1) % 4]) begin
                    mismatched++;
                    $display("FAIL full_seg cyc=%0d got %b want %b", cyc, seg, FULL_SEG[((cyc / 4) - 1) % 4]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_seg;
        run_to(66);
        msg_valid = 1'b1;
        msg_data  = MSG_A;
        step();
        msg_data = MSG_B;
        step();
        compared++; if (msg_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_hold got %b want 0", msg_ready); end
        run_to(79);
        compared++; if (msg_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_hold_late got %b want 0", msg_ready); end
        step();
        compared++; if (msg_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_commit_a got %b want 1", msg_ready); end
        step();
        msg_valid = 1'b0;
        compared++; if (msg_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_accept_b got %b want 0", msg_ready); end
        while (cyc < 112) begin
            step();
            if (cyc % 4 == 0) begin
                exp_seg = (cyc <= 96) ? A_SEG[((cyc / 4) - 1) % 4] : B_SEG[((cyc / 4) - 1) % 4];
                compared++;
                if (seg !== exp_seg) begin
                    mismatched++; $display("FAIL b2b_seg cyc=%0d got %b want %b", cyc, seg, exp_seg);
                end
            end
        end
    endtask

    task automatic test_accept_on_wrap();
        logic [6:0] exp_seg;
        run_to(127);
        msg_valid = 1'b1;
        msg_data  = MSG_C;
        step();
        msg_valid = 1'b0;
        compared++; if (msg_ready !== 1'b0) begin mismatched++; $display("FAIL wrap_acc_pending got %b want 0", msg_ready); end
        while (cyc < 160) begin
            step();
            if (cyc == 144) begin
                compared++;
                if (msg_ready !== 1'b1) begin mismatched++; $display("FAIL wrap_acc_commit got %b want 1", msg_ready); end
            end
            if (cyc % 4 == 0) begin
                exp_seg = (cyc <= 144) ? B_SEG[((cyc / 4) - 1) % 4] : C_SEG[((cyc / 4) - 1) % 4];
                compared++;
                if (seg !== exp_seg) begin
                    mismatched++; $display("FAIL wrap_acc_seg cyc=%0d got %b want %b", cyc, seg, exp_seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] exp_an;
        run_to(162);
        msg_valid = 1'b1;
        msg_data  = MSG_D;
        step();
        msg_valid = 1'b0;
        compared++; if (msg_ready !== 1'b0) begin mismatched++; $display("FAIL mid_pending got %b want 0", msg_ready); end
        #3 rst_n = 1'b0;
        #1;
        compared++; if (an !== 4'b1111) begin mismatched++; $display("FAIL mid_async_an got %b want 1111", an); end
        compared++; if (seg !== P_BLANK) begin mismatched++; $display("FAIL mid_async_seg got %b want %b", seg, P_BLANK); end
        compared++; if (msg_ready !== 1'b1) begin mismatched++; $display("FAIL mid_async_ready got %b want 1", msg_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        while (cyc < 24) begin
            step();
            compared++;
            if (msg_ready !== 1'b1) begin mismatched++; $display("FAIL mid_ready cyc=%0d got %b want 1", cyc, msg_ready); end
            if (cyc % 4 == 0) begin
                exp_an = AN_TAB[((cyc / 4) - 1) % 4];
                compared++;
                if (an !== exp_an) begin mismatched++; $display("FAIL mid_an cyc=%0d got %b want %b", cyc, an, exp_an); end
                compared++;
                if (seg !== P_BLANK) begin mismatched++; $display("FAIL mid_seg cyc=%0d got %b want %b", cyc, seg, P_BLANK); end
            end
        end
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        cyc        = 0;
        msg_valid  = 1'b1;
        msg_data   = MSG_A;
        blink_mask = 4'b0001;
        step();
        msg_valid = 1'b0;
        run_to(20);
        compared++; if (seg !== P_O) begin mismatched++; $display("FAIL blink_f1_d0 got %b want %b", seg, P_O); end
        run_to(36);
        compared++; if (seg !== P_BLANK) begin mismatched++; $display("FAIL blink_f2_d0 got %b want %b", seg, P_BLANK); end
        compared++; if (an !== 4'b1110) begin mismatched++; $display("FAIL blink_f2_an got %b want 1110", an); end
        run_to(40);
        compared++; if (seg !== P_P) begin mismatched++; $display("FAIL blink_f2_d1 got %b want %b", seg, P_P); end
        run_to(52);
        compared++; if (seg !== P_BLANK) begin mismatched++; $display("FAIL blink_f3_d0 got %b want %b", seg, P_BLANK); end
        run_to(68);
        compared++; if (seg !== P_O) begin mismatched++; $display("FAIL blink_f4_d0 got %b want %b", seg, P_O); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timing();
        test_load_full();
        test_back_to_back();
        test_accept_on_wrap();
        test_reset_mid_frame();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
